// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C sensor target.
package i2c_pkg;

  localparam int BYTE_BITS = 8;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTE_BITS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_MACK,
    ST_RX,
    ST_RX_ACK,
    ST_IGNORE,
    ST_WAIT
  } state_t;

  // The target owns the transfer from address match until START/STOP.
  function automatic logic is_busy(state_t s);
    return (s == ST_ADDR_ACK) || (s == ST_TX) || (s == ST_MACK) ||
           (s == ST_RX) || (s == ST_RX_ACK) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for scl/sda plus registered edge, START and STOP detection.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_level,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_reg;
  logic [1:0] sda_sync_reg;
  logic       scl_prev_reg;
  logic       sda_prev_reg;
  logic       scl_rise_reg;
  logic       scl_fall_reg;
  logic       start_reg;
  logic       stop_reg;

  // Idle bus is high, so syncs reset high to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl};
      sda_sync_reg <= {sda_sync_reg[0], sda};
      scl_prev_reg <= scl_sync_reg[1];
      sda_prev_reg <= sda_sync_reg[1];
      scl_rise_reg <= scl_sync_reg[1] & ~scl_prev_reg;
      scl_fall_reg <= ~scl_sync_reg[1] & scl_prev_reg;
      start_reg    <= ~sda_sync_reg[1] & sda_prev_reg & scl_sync_reg[1] & scl_prev_reg;
      stop_reg     <= sda_sync_reg[1] & ~sda_prev_reg & scl_sync_reg[1] & scl_prev_reg;
    end
  end

  // Levels are taken one stage late so they line up with the event registers.
  assign scl_level = scl_prev_reg;
  assign sda_level = sda_prev_reg;
  assign scl_rise  = scl_rise_reg;
  assign scl_fall  = scl_fall_reg;
  assign start_det = start_reg;
  assign stop_det  = stop_reg;

endmodule

// File: rtl/i2c_sensor_target.sv
// Oversampling I2C target: returns sample_in on reads, captures write bytes on rx_data.
module i2c_sensor_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  input  logic [7:0] sample_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sda_oe
);

  logic scl_level;
  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bit_strobe;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             oe_reg, oe_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_level (scl_level),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign bit_strobe = scl_rise & scl_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      oe_reg       <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      oe_reg       <= oe_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    oe_next       = oe_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    if (start_det) begin
      state_next = ST_ADDR;
      cnt_next   = CNT_FULL;
      oe_next    = 1'b0;
    end else if (stop_det) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      oe_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR: begin
          if (bit_strobe && cnt_reg != '0) begin
            shift_next = {shift_reg[6:0], sda_level};
            cnt_next   = cnt_reg - 1'b1;
          end else if (scl_fall && cnt_reg == '0) begin
            if (shift_reg[7:1] == ADDR) begin
              state_next = ST_ADDR_ACK;
              oe_next    = 1'b1;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (shift_reg[0]) begin
              // Bit 7 goes out on this same fall, so the register holds the remaining bits.
              state_next = ST_TX;
              shift_next = {sample_in[6:0], 1'b0};
              oe_next    = ~sample_in[7];
              cnt_next   = CNT_FULL - 1'b1;
            end else begin
              state_next = ST_RX;
              oe_next    = 1'b0;
              cnt_next   = CNT_FULL;
            end
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_reg == '0) begin
              state_next = ST_MACK;
              oe_next    = 1'b0;
            end else begin
              oe_next    = ~shift_reg[7];
              shift_next = {shift_reg[6:0], 1'b0};
              cnt_next   = cnt_reg - 1'b1;
            end
          end
        end
        ST_MACK: begin
          if (bit_strobe) begin
            if (!sda_level) begin
              state_next = ST_TX;
              shift_next = sample_in;
              cnt_next   = CNT_FULL;
            end else begin
              state_next = ST_WAIT;
            end
          end
        end
        ST_RX: begin
          if (bit_strobe && cnt_reg != '0) begin
            shift_next = {shift_reg[6:0], sda_level};
            cnt_next   = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
              rx_data_next  = {shift_reg[6:0], sda_level};
              rx_valid_next = 1'b1;
            end
          end else if (scl_fall && cnt_reg == '0) begin
            state_next = ST_RX_ACK;
            oe_next    = 1'b1;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            state_next = ST_RX;
            oe_next    = 1'b0;
            cnt_next   = CNT_FULL;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda      = oe_reg ? 1'b0 : 1'bz;
  assign sda_oe   = oe_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = is_busy(state_reg);

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Directed bench: bit-banged I2C master against i2c_sensor_target with hand-computed expectations.
module tb_i2c_sensor_target;
  import i2c_pkg::*;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic [7:0] sample_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sda_oe;
  wire        sda;

  int checks = 0;
  int errors = 0;
  int rx_valid_cycles = 0;
  int oe_cycles = 0;
  logic last_oe;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_sensor_target #(.ADDR(7'h55)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sample_in (sample_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sda_oe    (sda_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rx_valid_cycles <= rx_valid_cycles + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; wclk(5);
    scl = 1'b1;   wclk(10);
    m_low = 1'b1; wclk(10);
    scl = 1'b0;   wclk(10);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wclk(10);
    scl = 1'b1;   wclk(10);
    m_low = 1'b0; wclk(10);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wclk(10);
    scl = 1'b1; wclk(10);
    last_oe = sda_oe; wclk(10);
    scl = 1'b0; wclk(10);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wclk(10);
    scl = 1'b1;   wclk(10);
    b = sda;      wclk(10);
    scl = 1'b0;   wclk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; sample_in = 8'h00;
    wclk(3);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_reg, ST_IDLE); end
    rst = 1'b0; wclk(5);
    $display("test_reset done");
  endtask

  task automatic test_read_nack();
    logic ack;
    logic [7:0] d;
    sample_in = 8'h0F;
    bus_start();
    write_byte(8'hAB, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b exp 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", busy); end
    read_byte(d);
    checks++; if (d !== 8'h0F) begin errors++; $display("FAIL rd_data got %h exp 0f", d); end
    write_bit(1'b1);
    checks++; if (dut.state_reg !== ST_WAIT) begin errors++; $display("FAIL rd_nack_state got %0d exp %0d", dut.state_reg, ST_WAIT); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_stop_busy got %b exp 0", busy); end
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL rd_stop_state got %0d exp %0d", dut.state_reg, ST_IDLE); end
    $display("test_read_nack: addr 0xAB data %h", d);
  endtask

  task automatic test_read_ack();
    logic ack;
    logic b;
    logic [7:0] d1, d2;
    sample_in = 8'h0F;
    bus_start();
    write_byte(8'hAB, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rda_addr_ack got %b exp 0", ack); end
    read_byte(d1);
    checks++; if (d1 !== 8'h0F) begin errors++; $display("FAIL rda_byte1 got %h exp 0f", d1); end
    sample_in = 8'h3C;
    write_bit(1'b0);
    checks++; if (last_oe !== 1'b0) begin errors++; $display("FAIL rda_mack_drive got %b exp 0", last_oe); end
    // Changing sample_in mid-byte must not disturb the byte in flight.
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) sample_in = 8'hFF;
      read_bit(b);
      d2[i] = b;
    end
    checks++; if (d2 !== 8'h3C) begin errors++; $display("FAIL rda_byte2 got %h exp 3c", d2); end
    write_bit(1'b1);
    bus_stop();
    $display("test_read_ack: bytes %h %h", d1, d2);
  endtask

  task automatic test_write();
    logic ack1, ack2;
    int v0;
    v0 = rx_valid_cycles;
    bus_start();
    write_byte(8'hAA, ack1);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b exp 0", ack1); end
    write_byte(8'h96, ack2);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL wr_data_ack got %b exp 0", ack2); end
    checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL wr_rx_data got %h exp 96", rx_data); end
    checks++; if (rx_valid_cycles - v0 !== 1) begin errors++; $display("FAIL wr_rx_valid_cycles got %0d exp 1", rx_valid_cycles - v0); end
    bus_stop();
    $display("test_write: rx_data %h", rx_data);
  endtask

  task automatic test_ignore();
    logic ack;
    logic [7:0] d;
    int oe0;
    sample_in = 8'h81;
    oe0 = oe_cycles;
    bus_start();
    write_byte(8'h45, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ign_ack got %b exp 1", ack); end
    checks++; if (oe_cycles - oe0 !== 0) begin errors++; $display("FAIL ign_oe_cycles got %0d exp 0", oe_cycles - oe0); end
    checks++; if (dut.state_reg !== ST_IGNORE) begin errors++; $display("FAIL ign_state got %0d exp %0d", dut.state_reg, ST_IGNORE); end
    bus_start();
    write_byte(8'hAB, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ign_next_ack got %b exp 0", ack); end
    read_byte(d);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL ign_next_data got %h exp 81", d); end
    write_bit(1'b1);
    bus_stop();
    $display("test_ignore: follow-up read %h", d);
  endtask

  task automatic test_rep_start();
    logic ack;
    logic b;
    logic [3:0] hi;
    logic [7:0] d;
    sample_in = 8'hAD;
    bus_start();
    write_byte(8'hAB, ack);
    for (int i = 3; i >= 0; i--) begin
      read_bit(b);
      hi[i] = b;
    end
    checks++; if (hi !== 4'hA) begin errors++; $display("FAIL rs_first_bits got %h exp a", hi); end
    sample_in = 8'h5A;
    bus_start();
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rs_release got %b exp 0", sda_oe); end
    checks++; if (dut.state_reg !== ST_ADDR) begin errors++; $display("FAIL rs_state got %0d exp %0d", dut.state_reg, ST_ADDR); end
    write_byte(8'hAB, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b exp 0", ack); end
    read_byte(d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rs_data got %h exp 5a", d); end
    write_bit(1'b1);
    bus_stop();
    $display("test_rep_start: first nibble %h new read %h", hi, d);
  endtask

  task automatic test_rst_mid();
    logic ack;
    sample_in = 8'h00;
    bus_start();
    write_byte(8'hAB, ack);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_drive got %b exp 1", sda_oe); end
    rst = 1'b1;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", sda_oe); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda got %b exp 1", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
    wclk(2);
    rst = 1'b0;
    bus_stop();
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL rst_after_state got %0d exp %0d", dut.state_reg, ST_IDLE); end
    $display("test_rst_mid done");
  endtask

  initial begin
    test_reset();
    test_read_nack();
    test_read_ack();
    test_write();
    test_ignore();
    test_rep_start();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_target.md
# i2c_sensor_target

I2C target (slave) that models the voltage sensor on the board's two-wire bus. It answers the 7-bit address `ADDR` and, on a read, shifts out an 8-bit sample taken from `sample_in`. On a write, it captures the data bytes and presents them on `rx_data`. It sits on the same `scl`/`sda` pair as the bus master and runs from the system clock. It oversamples the bus rather than clocking on `scl`.

## Interface
Parameters:
- `ADDR`, default 7'h55: target address; address byte 0xAB is a read of 0x55.

Ports:
- `clk`  in  1  system clock, at least 8x the SCL frequency.
- `rst`  in  1  reset, asynchronous and active-high.
- `scl`  in  1  bus clock from the master; this block never stretches it.
- `sda`  inout  1  open-drain data line; driven low only when `sda_oe` is 1, else `1'bZ`.
- `sample_in`  in  8  sensor value; latched at each byte load for transmit.
- `rx_data`  out  8  last byte received in a write transfer.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from an address match until the STOP or repeated START.
- `sda_oe`  out  1  internal pull-low enable, exported for debug.

## Operation
- Inputs `scl` and `sda` pass through 2-flop synchronizers, then edge detectors. All decisions use these synchronized signals.
- START is a falling `sda` while `scl` is high. From any state, START → ADDR: bit count = 8, `sda_oe` = 0.
- STOP is a rising `sda` while `scl` is high. From any state, STOP → IDLE: `sda_oe` = 0, `busy` = 0.
- Bits are sampled on the detected `scl` rising edge, MSB first. `sda_oe` changes only on the detected `scl` falling edge.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. After the 8th bit, on the following `scl` fall:
    - if `[7:1]` equals ADDR → ADDR_ACK and drive 0;
    - otherwise → IGNORE.
  - ADDR_ACK: on the next `scl` fall, release the ACK.
    - R/W = 1 → TX: load shift register with `sample_in` and drive bit 7.
    - R/W = 0 → RX.
  - TX: drive `sda_oe` = ~bit. After the 8th `scl` fall, release → MACK.
  - MACK: sample master `sda` on `scl` rise.
    - 0 (ACK) → reload `sample_in` and go to TX (continuous read).
    - 1 (NACK) → WAIT.
  - RX: shift in 8 bits. After the 8th rise:
    - update `rx_data` and pulse `rx_valid`;
    - on the next `scl` fall, drive ACK → RX_ACK.
  - RX_ACK: on the next `scl` fall, release → RX.
  - IGNORE and WAIT: `sda_oe` = 0; leave only on START or STOP.
- `busy` = 1 in ADDR_ACK, TX, MACK, RX, RX_ACK and WAIT.

## Timing
- Reset values: state IDLE, `sda_oe` 0, `rx_data` 0x00, `rx_valid` 0, `busy` 0, bit count 0, shift register 0.
- Detection latency: 3 `clk` from a bus pin change to its edge event (2 sync + 1 edge register).
- `sda_oe` updates 1 `clk` after the detected `scl` fall, so data is valid well before the next `scl` rise.
- `rx_valid` asserts 1 `clk` after the detected 8th rise and is high for exactly 1 `clk`.
- If a START/STOP event and an `scl` edge are detected in the same cycle, START/STOP wins.
- A repeated START in mid-byte aborts the byte: `rx_valid` does not pulse and `rx_data` is unchanged.
- `rst` asserted mid-transfer releases `sda` immediately (asynchronous), with all regs at reset values.
- `sample_in` is latched only at a byte load. Changes mid-byte do not affect the bits being shifted.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, TX, MACK, RX, RX_ACK, IGNORE, WAIT);
  - the bit-count width and `BYTE_BITS` = 8.
- Sub-module `i2c_line_sync`: 2-flop synchronizers plus edge detection for `scl` and `sda`. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det` and the synced levels.

## Test plan
- Read 0x55 (byte 0xAB) with `sample_in`=0x0F, then master NACK → target ACKs the address, master receives 0x0F, STOP returns to IDLE and `busy` falls.
- Read with master ACK, `sample_in` changed to 0x3C between bytes → bytes 0x0F then 0x3C, with no drive during MACK.
- Write 0x55 (byte 0xAA) then data 0x96 → two target ACKs, `rx_data`=0x96, `rx_valid` high for 1 cycle.
- Address 0x22 read → `sda_oe` never asserts and the state reaches IGNORE. A subsequent START with 0xAB is acknowledged.
- Repeated START after 4 TX bits, then a new read → `sda` is released and the new transfer returns a fresh `sample_in`.
- `rst` pulse while driving a 0 bit → `sda` goes Z in the same cycle, and all outputs return to reset values.
